index_mif_reader: RTL and testbench

- Read-side counterpart of the index-memory writer: scans the 640x480, 3-bit-per-pixel index memory in raster order and drives VGA output.
- Generates 640x480@60 timing and issues sequential read addresses to the memory's read port.
- Maps each 3-bit index through an 8-entry, run-time-writable RGB palette.
- Exports frame_start and in_vblank so writers can schedule updates against the scan.

---
 rtl/index_mif_reader.sv | 151 +++++++++++++++
 tb/tb_index_mif_reader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/index_mif_reader.sv
// Raster-scans the 3-bit index memory and drives 640x480@60 VGA through an 8-entry RGB palette.
// Latency: 2 cycles from counter state to pins; mem_raddr leads the pixel by one cycle for the sync RAM.
// Backpressure: none, free-running pixel pipeline; palette writes accepted every cycle.
module index_mif_reader #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clock,
    input  logic        reset,
    output logic [18:0] mem_raddr,
    input  logic [2:0]  mem_rdata,
    input  logic        pal_we,
    input  logic [2:0]  pal_idx,
    input  logic [23:0] pal_data,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        frame_start,
    output logic        in_vblank
);

    localparam logic [9:0]  H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0]  H_SB     = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]  H_SE     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]  H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0]  V_SB     = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  V_SE     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [18:0] PIX_LAST = 19'(H_VISIBLE * V_VISIBLE - 1);

    localparam logic [23:0] PAL_DEFAULT [8] = '{
        24'h000000, 24'hFFFFFF, 24'h00FF00, 24'hFF0000,
        24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF
    };

    logic        running;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        vis0;
    logic        hs0;
    logic        vs0;
    logic [18:0] pix_addr;
    logic        vis1;
    logic        hs1;
    logic        vs1;
    logic [23:0] pal [8];
    logic [23:0] rgb_q;
    logic        hs_q;
    logic        vs_q;
    logic        blank_n_q;

    // Holds the counters at (0,0) for the first edge after release so that
    // edge starts pixel (0,0) instead of stepping past it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            running <= 1'b0;
        end else begin
            running <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (running) begin
            if (h_count == H_LAST) begin
                h_count <= '0;
                v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;
            end else begin
                h_count <= h_count + 10'd1;
            end
        end
    end

    always_comb begin
        vis0 = running && (h_count < H_VIS) && (v_count < V_VIS);
        hs0  = !((h_count >= H_SB) && (h_count < H_SE));
        vs0  = !((v_count >= V_SB) && (v_count < V_SE));
    end

    assign frame_start = running && (h_count == '0) && (v_count == '0);
    assign in_vblank   = (v_count >= V_VIS);

    // Advancing only on visible pixels leaves the next pixel's address
    // already on the bus during blanking, hiding the RAM's read latency.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pix_addr <= '0;
        end else if (vis0) begin
            pix_addr <= (pix_addr == PIX_LAST) ? '0 : pix_addr + 19'd1;
        end
    end

    assign mem_raddr = pix_addr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vis1 <= 1'b0;
            hs1  <= 1'b1;
            vs1  <= 1'b1;
        end else begin
            vis1 <= vis0;
            hs1  <= hs0;
            vs1  <= vs0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                pal[i] <= PAL_DEFAULT[i];
            end
        end else if (pal_we) begin
            pal[pal_idx] <= pal_data;
        end
    end

    // Lookup reads the pre-edge palette, so a same-cycle write shows up one pixel later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rgb_q     <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            rgb_q     <= vis1 ? pal[mem_rdata] : '0;
            hs_q      <= hs1;
            vs_q      <= vs1;
            blank_n_q <= vis1;
        end
    end

    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;

endmodule

// File: tb/tb_index_mif_reader.sv
// Bench for index_mif_reader: a full-size instance for exact 640x480 timing points and
// a shrunk-timing instance so whole frames fit in a short run; both checked every cycle.
module tb_index_mif_reader;

    localparam int HV_A [2] = '{640, 40};
    localparam int HF_A [2] = '{16, 4};
    localparam int HS_A [2] = '{96, 8};
    localparam int HB_A [2] = '{48, 6};
    localparam int VV_A [2] = '{480, 30};
    localparam int VF_A [2] = '{10, 3};
    localparam int VS_A [2] = '{2, 2};
    localparam int VB_A [2] = '{33, 4};

    localparam logic [23:0] PAL_DEF [8] = '{
        24'h000000, 24'hFFFFFF, 24'h00FF00, 24'hFF0000,
        24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF
    };

    logic        clock = 1'b0;
    logic        reset;
    logic        pal_we;
    logic [2:0]  pal_idx;
    logic [23:0] pal_data;

    logic [18:0] f_raddr, s_raddr;
    logic [2:0]  f_rdata, s_rdata;
    logic [7:0]  f_r, f_g, f_b, s_r, s_g, s_b;
    logic        f_hs, f_vs, f_bl, f_fs, f_vb;
    logic        s_hs, s_vs, s_bl, s_fs, s_vb;

    logic [2:0]  f_mem [307200];
    logic [2:0]  s_mem [1200];
    logic [23:0] m_pal [8];

    int n      = -1;
    int n_pass = 0;
    int n_chk  = 0;
    bit chk_en = 1'b0;

    logic [23:0] e_rgb [2];
    logic [18:0] e_ra  [2];
    logic        e_hs  [2];
    logic        e_vs  [2];
    logic        e_bl  [2];
    logic        e_fs  [2];
    logic        e_vb  [2];

    always #5 clock = ~clock;

    index_mif_reader u_full (
        .clock(clock), .reset(reset),
        .mem_raddr(f_raddr), .mem_rdata(f_rdata),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
        .vga_r(f_r), .vga_g(f_g), .vga_b(f_b),
        .vga_hs(f_hs), .vga_vs(f_vs), .vga_blank_n(f_bl),
        .frame_start(f_fs), .in_vblank(f_vb)
    );

    index_mif_reader #(
        .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(8), .H_BACK(6),
        .V_VISIBLE(30), .V_FRONT(3), .V_SYNC(2), .V_BACK(4)
    ) u_small (
        .clock(clock), .reset(reset),
        .mem_raddr(s_raddr), .mem_rdata(s_rdata),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .vga_hs(s_hs), .vga_vs(s_vs), .vga_blank_n(s_bl),
        .frame_start(s_fs), .in_vblank(s_vb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    function automatic int h_tot(int k);
        return HV_A[k] + HF_A[k] + HS_A[k] + HB_A[k];
    endfunction

    function automatic int v_tot(int k);
        return VV_A[k] + VF_A[k] + VS_A[k] + VB_A[k];
    endfunction

    // Address on the read port while the scan sits at (h,v): count of visible
    // pixels already passed this frame, wrapping at the frame size.
    function automatic int addr_of(int k, int h, int v);
        if (v >= VV_A[k]) return 0;
        return (v * HV_A[k] + ((h < HV_A[k]) ? h : HV_A[k])) % (HV_A[k] * VV_A[k]);
    endfunction

    function automatic bit visible(int k, int p);
        if (p < 0) return 1'b0;
        return ((p % h_tot(k)) < HV_A[k]) && (((p / h_tot(k)) % v_tot(k)) < VV_A[k]);
    endfunction

    function automatic logic [2:0] mem_at(int k, int a);
        return (k == 0) ? f_mem[a] : s_mem[a];
    endfunction

    task automatic set_reset_exp(input int k);
        e_rgb[k] = '0;
        e_ra[k]  = '0;
        e_hs[k]  = 1'b1;
        e_vs[k]  = 1'b1;
        e_bl[k]  = 1'b0;
        e_fs[k]  = 1'b0;
        e_vb[k]  = 1'b0;
    endtask

    // Expected pins for cycle n: scan-position outputs follow pixel n, the
    // VGA pins show pixel n-2.
    task automatic model_cycle(input int k);
        int h0, v0, p, h, v;
        h0 = n % h_tot(k);
        v0 = (n / h_tot(k)) % v_tot(k);
        e_fs[k] = (h0 == 0) && (v0 == 0);
        e_vb[k] = (v0 >= VV_A[k]);
        e_ra[k] = 19'(addr_of(k, h0, v0));
        p = n - 2;
        if (p < 0) begin
            e_rgb[k] = '0;
            e_hs[k]  = 1'b1;
            e_vs[k]  = 1'b1;
            e_bl[k]  = 1'b0;
        end else begin
            h = p % h_tot(k);
            v = (p / h_tot(k)) % v_tot(k);
            e_bl[k]  = visible(k, p);
            e_hs[k]  = !((h >= HV_A[k] + HF_A[k]) && (h < HV_A[k] + HF_A[k] + HS_A[k]));
            e_vs[k]  = !((v >= VV_A[k] + VF_A[k]) && (v < VV_A[k] + VF_A[k] + VS_A[k]));
            e_rgb[k] = e_bl[k] ? m_pal[mem_at(k, addr_of(k, h, v))] : 24'h000000;
        end
    endtask

    // Reference model plus synchronous RAMs; blanking reads return 7 so any
    // leak of mem_rdata outside the visible area shows up as colour.
    initial forever begin
        @(posedge clock);
        if (!reset) begin
            n = -1;
            for (int i = 0; i < 8; i++) m_pal[i] = PAL_DEF[i];
            for (int k = 0; k < 2; k++) set_reset_exp(k);
            f_rdata <= 3'd7;
            s_rdata <= 3'd7;
        end else begin
            n = n + 1;
            for (int k = 0; k < 2; k++) model_cycle(k);
            if (pal_we) m_pal[pal_idx] = pal_data;
            f_rdata <= (visible(0, n - 1) && f_raddr < 19'd307200) ? f_mem[f_raddr] : 3'd7;
            s_rdata <= (visible(1, n - 1) && s_raddr < 19'd1200) ? s_mem[s_raddr] : 3'd7;
        end
    end

    task automatic check_outs(input int k, input logic [23:0] rgb, input logic [18:0] ra,
                              input logic hs, input logic vs, input logic bl,
                              input logic fs, input logic vb);
        string t;
        t = (k == 0) ? "full_" : "small_";
        check({t, "rgb"},   32'(rgb), 32'(e_rgb[k]));
        check({t, "raddr"}, 32'(ra),  32'(e_ra[k]));
        check({t, "hs"},    32'(hs),  32'(e_hs[k]));
        check({t, "vs"},    32'(vs),  32'(e_vs[k]));
        check({t, "blank"}, 32'(bl),  32'(e_bl[k]));
        check({t, "fstart"},32'(fs),  32'(e_fs[k]));
        check({t, "vblank"},32'(vb),  32'(e_vb[k]));
    endtask

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            check_outs(0, {f_r, f_g, f_b}, f_raddr, f_hs, f_vs, f_bl, f_fs, f_vb);
            check_outs(1, {s_r, s_g, s_b}, s_raddr, s_hs, s_vs, s_bl, s_fs, s_vb);
        end
    end

    task automatic wait_n(input int k);
        int g;
        g = 0;
        while (n < k && g < 5000) begin
            @(negedge clock);
            g++;
        end
        if (n != k) check("wait_cycle", 32'(n), 32'(k));
    endtask

    task automatic check_reset_pins(input string t);
        check({t, "_hs"},    32'(f_hs),  32'd1);
        check({t, "_vs"},    32'(f_vs),  32'd1);
        check({t, "_blank"}, 32'(f_bl),  32'd0);
        check({t, "_rgb"},   32'({f_r, f_g, f_b}), 32'd0);
        check({t, "_raddr"}, 32'(f_raddr), 32'd0);
        check({t, "_fstart"},32'(f_fs),  32'd0);
        check({t, "_sblank"},32'(s_bl),  32'd0);
        check({t, "_sraddr"},32'(s_raddr), 32'd0);
    endtask

    initial begin
        int fs_cnt;
        reset    = 1'b0;
        pal_we   = 1'b0;
        pal_idx  = '0;
        pal_data = '0;
        for (int i = 0; i < 307200; i++) f_mem[i] = 3'd0;
        f_mem[5]  = 3'd2;
        f_mem[20] = 3'd2;
        f_mem[21] = 3'd2;
        for (int i = 0; i < 1200; i++) s_mem[i] = 3'($urandom);
        chk_en = 1'b1;

        repeat (4) @(negedge clock);
        check_reset_pins("rst_hold");
        reset = 1'b1;

        wait_n(1);   check("blank_c1", 32'(f_bl), 32'd0);
        wait_n(2);   check("blank_c2", 32'(f_bl), 32'd1);
        wait_n(6);   check("px4_rgb",  32'({f_r, f_g, f_b}), 32'h000000);
        wait_n(7);   check("px5_rgb",  32'({f_r, f_g, f_b}), 32'h00FF00);
        wait_n(8);   check("px6_rgb",  32'({f_r, f_g, f_b}), 32'h000000);

        wait_n(21);
        pal_we   = 1'b1;
        pal_idx  = 3'd2;
        pal_data = 24'h123456;
        wait_n(22);
        pal_we   = 1'b0;
        check("palwr_old", 32'({f_r, f_g, f_b}), 32'h00FF00);
        wait_n(23);  check("palwr_new", 32'({f_r, f_g, f_b}), 32'h123456);

        wait_n(639); check("raddr_639",  32'(f_raddr), 32'd639);
        wait_n(640); check("raddr_640",  32'(f_raddr), 32'd640);
        wait_n(641); check("blank_c641", 32'(f_bl), 32'd1);
        wait_n(642); check("blank_c642", 32'(f_bl), 32'd0);
        wait_n(657); check("hs_c657",    32'(f_hs), 32'd1);
        wait_n(658); check("hs_c658",    32'(f_hs), 32'd0);
        wait_n(753); check("hs_c753",    32'(f_hs), 32'd0);
        wait_n(754); check("hs_c754",    32'(f_hs), 32'd1);
        wait_n(799); check("raddr_799",  32'(f_raddr), 32'd640);
        wait_n(800); check("raddr_800",  32'(f_raddr), 32'd640);
        wait_n(801); check("raddr_801",  32'(f_raddr), 32'd641);
        wait_n(1458); check("hs_c1458",  32'(f_hs), 32'd0);

        wait_n(1460);
        check("pre_rst_hs", 32'(f_hs), 32'd0);
        #2 reset = 1'b0;
        #1 check_reset_pins("async_rst");

        repeat (3) @(negedge clock);
        for (int i = 0; i < 307200; i++) f_mem[i] = 3'($urandom);
        for (int i = 0; i < 1200; i++) s_mem[i] = 3'($urandom);
        reset  = 1'b1;
        fs_cnt = 0;
        repeat (3 * 2262 + 20) begin
            @(negedge clock);
            if (s_fs) fs_cnt++;
            if ($urandom_range(0, 7) == 0) begin
                pal_we   = 1'b1;
                pal_idx  = 3'($urandom);
                pal_data = 24'($urandom);
            end else begin
                pal_we = 1'b0;
            end
        end
        pal_we = 1'b0;
        check("small_fstart_count", 32'(fs_cnt), 32'd4);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
